ecc_scrubber: RTL and testbench

- Background scrub initiator that sits between the CPU port and ecc_ram and owns ecc_ram's data_in/addr/write_en/read_en port.
- CPU accesses pass through with strict priority. In idle cycles the block walks every RAM address, reads it, and writes corrected data back on a single-bit error.
- Double-bit errors are counted and logged, never written back.
- Keeps latent single-bit upsets from accumulating into uncorrectable double-bit errors.

---
 rtl/ecc_scrubber.sv | 191 +++++++++++++++++++
 tb/tb_ecc_scrubber.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: owns the ecc_ram port, passes CPU accesses through with
// priority, and in idle time walks every address, writing back single-bit corrections.
module ecc_scrubber #(
    parameter int DATA_WIDTH     = 16,
    parameter int RAM_DEPTH      = 256,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16,
    localparam int AW            = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en,
    input  logic [DATA_WIDTH-1:0] cpu_data_in,
    input  logic [AW-1:0]         cpu_addr,
    input  logic                  cpu_write_en,
    input  logic                  cpu_read_en,
    output logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic                  cpu_single_error,
    output logic                  cpu_double_error,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [AW-1:0]         ram_addr,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_single_error,
    input  logic                  ram_double_error,
    output logic                  scrub_busy,
    output logic                  pass_done,
    output logic [CNT_WIDTH-1:0]  corrected_count,
    output logic [CNT_WIDTH-1:0]  uncorrectable_count,
    output logic [AW-1:0]         last_err_addr
);

    localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [AW-1:0]        LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [IW-1:0]        INT_LAST  = IW'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_READ, S_CHECK, S_WRITEBACK, S_NEXT
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [IW-1:0]         icnt_q, icnt_d;
    logic [CNT_WIDTH-1:0]  corr_q, corr_d;
    logic [CNT_WIDTH-1:0]  unc_q, unc_d;
    logic [AW-1:0]         last_err_q, last_err_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  pass_q, pass_d;
    logic                  cpu_rd_q, cpu_rd_d;

    logic cpu_active;
    logic cpu_hit;
    logic scrub_rd;
    logic scrub_wr;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign cpu_active = cpu_write_en | cpu_read_en;
    // A CPU write to the address being scrubbed makes any pending writeback stale.
    assign cpu_hit    = cpu_write_en && (cpu_addr == addr_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        icnt_d     = icnt_q;
        corr_d     = corr_q;
        unc_d      = unc_q;
        last_err_d = last_err_q;
        wb_data_d  = wb_data_q;
        pass_d     = 1'b0;
        scrub_rd   = 1'b0;
        scrub_wr   = 1'b0;
        cpu_rd_d   = cpu_read_en & ~cpu_write_en;
        case (state_q)
            S_IDLE: begin
                if (scrub_en) begin
                    state_d = S_WAIT;
                    icnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (!scrub_en) begin
                    state_d = S_IDLE;
                end else if (!cpu_active) begin
                    if (icnt_q == INT_LAST) begin
                        state_d = S_READ;
                        icnt_d  = '0;
                    end else begin
                        icnt_d = icnt_q + IW'(1);
                    end
                end
            end
            S_READ: begin
                if (!cpu_active) begin
                    scrub_rd = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_NEXT;
                if (ram_single_error) begin
                    corr_d     = sat_inc(corr_q);
                    last_err_d = addr_q;
                    wb_data_d  = ram_data_out;
                    if (!cpu_hit) state_d = S_WRITEBACK;
                end else if (ram_double_error) begin
                    unc_d      = sat_inc(unc_q);
                    last_err_d = addr_q;
                end
            end
            S_WRITEBACK: begin
                if (cpu_hit) begin
                    state_d = S_NEXT;
                end else if (!cpu_active) begin
                    scrub_wr = 1'b1;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d = '0;
                    pass_d = 1'b1;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
                icnt_d  = '0;
                state_d = scrub_en ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CPU strobes take the port outright; write beats read.
    always_comb begin
        if (cpu_write_en) begin
            ram_data_in  = cpu_data_in;
            ram_addr     = cpu_addr;
            ram_write_en = 1'b1;
            ram_read_en  = 1'b0;
        end else if (cpu_read_en) begin
            ram_data_in  = cpu_data_in;
            ram_addr     = cpu_addr;
            ram_write_en = 1'b0;
            ram_read_en  = 1'b1;
        end else begin
            ram_data_in  = scrub_wr ? wb_data_q : '0;
            ram_addr     = addr_q;
            ram_write_en = scrub_wr;
            ram_read_en  = scrub_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            icnt_q     <= '0;
            corr_q     <= '0;
            unc_q      <= '0;
            last_err_q <= '0;
            wb_data_q  <= '0;
            pass_q     <= 1'b0;
            cpu_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            icnt_q     <= icnt_d;
            corr_q     <= corr_d;
            unc_q      <= unc_d;
            last_err_q <= last_err_d;
            wb_data_q  <= wb_data_d;
            pass_q     <= pass_d;
            cpu_rd_q   <= cpu_rd_d;
        end
    end

    assign cpu_data_out        = ram_data_out;
    assign cpu_single_error    = ram_single_error & cpu_rd_q;
    assign cpu_double_error    = ram_double_error & cpu_rd_q;
    assign scrub_busy          = (state_q == S_READ) || (state_q == S_CHECK) ||
                                 (state_q == S_WRITEBACK) || (state_q == S_NEXT);
    assign pass_done           = pass_q;
    assign corrected_count     = corr_q;
    assign uncorrectable_count = unc_q;
    assign last_err_addr       = last_err_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber with a behavioural ecc_ram that reports injected errors.
module tb_ecc_scrubber;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, scrub_en;
    logic [DW-1:0] cpu_data_in, cpu_data_out, ram_data_in, ram_data_out;
    logic [AW-1:0] cpu_addr, ram_addr, last_err_addr;
    logic          cpu_write_en, cpu_read_en, cpu_single_error, cpu_double_error;
    logic          ram_write_en, ram_read_en, ram_single_error, ram_double_error;
    logic          scrub_busy, pass_done;
    logic [CW-1:0] corrected_count, uncorrectable_count;

    ecc_scrubber #(
        .DATA_WIDTH(DW), .RAM_DEPTH(256), .SCRUB_INTERVAL(4), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
        .cpu_data_in(cpu_data_in), .cpu_addr(cpu_addr),
        .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
        .cpu_data_out(cpu_data_out), .cpu_single_error(cpu_single_error),
        .cpu_double_error(cpu_double_error),
        .ram_data_in(ram_data_in), .ram_addr(ram_addr),
        .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .ram_data_out(ram_data_out), .ram_single_error(ram_single_error),
        .ram_double_error(ram_double_error),
        .scrub_busy(scrub_busy), .pass_done(pass_done),
        .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count),
        .last_err_addr(last_err_addr)
    );

    // Narrow-counter instance whose RAM always reports a single-bit error.
    logic [DW-1:0] sat_cpu_data_out, sat_ram_data_in;
    logic [1:0]    sat_ram_addr, sat_last_err;
    logic          sat_cse, sat_cde, sat_we, sat_re, sat_busy, sat_pass;
    logic [3:0]    sat_corr, sat_unc;

    ecc_scrubber #(
        .DATA_WIDTH(DW), .RAM_DEPTH(4), .SCRUB_INTERVAL(1), .CNT_WIDTH(4)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
        .cpu_data_in(16'h0000), .cpu_addr(2'b00),
        .cpu_write_en(1'b0), .cpu_read_en(1'b0),
        .cpu_data_out(sat_cpu_data_out), .cpu_single_error(sat_cse),
        .cpu_double_error(sat_cde),
        .ram_data_in(sat_ram_data_in), .ram_addr(sat_ram_addr),
        .ram_write_en(sat_we), .ram_read_en(sat_re),
        .ram_data_out(16'h0000), .ram_single_error(1'b1),
        .ram_double_error(1'b0),
        .scrub_busy(sat_busy), .pass_done(sat_pass),
        .corrected_count(sat_corr), .uncorrectable_count(sat_unc),
        .last_err_addr(sat_last_err)
    );

    // Behavioural ecc_ram: err 0 = clean, 1 = single-bit upset, 2 = double-bit upset.
    logic [DW-1:0] mem [256];
    logic [1:0]    err [256];
    logic          ram_clr, inj_en;
    logic [AW-1:0] inj_addr;
    logic [DW-1:0] inj_data;
    logic [1:0]    inj_err;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= '0;
                err[i] <= 2'd0;
            end
        end else if (inj_en) begin
            mem[inj_addr] <= inj_data;
            err[inj_addr] <= inj_err;
        end else if (ram_write_en) begin
            mem[ram_addr] <= ram_data_in;
            err[ram_addr] <= 2'd0;
        end
        if (ram_read_en) begin
            ram_data_out     <= mem[ram_addr];
            ram_single_error <= (err[ram_addr] == 2'd1);
            ram_double_error <= (err[ram_addr] == 2'd2);
        end
    end

    // Port activity monitor, sampled mid-cycle.
    int            cyc = 0, sr_cnt = 0, sr_prev_t = 0, sr_last_t = 0, seq_err = 0;
    int            sw_cnt = 0, pd_cnt = 0, wr40 = 0, spurious = 0;
    logic [AW-1:0] sr_last_addr = '0, exp_addr = '0;
    logic          cpu_rd_window = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && ram_read_en && !cpu_read_en && !cpu_write_en) begin
            sr_cnt       <= sr_cnt + 1;
            sr_prev_t    <= sr_last_t;
            sr_last_t    <= cyc;
            sr_last_addr <= ram_addr;
            exp_addr     <= ram_addr + 8'd1;
            if (ram_addr != exp_addr) seq_err <= seq_err + 1;
        end
        if (rst_n && ram_write_en && !cpu_write_en) sw_cnt <= sw_cnt + 1;
        if (pass_done) pd_cnt <= pd_cnt + 1;
        if (ram_write_en && ram_addr == 8'h40) wr40 <= wr40 + 1;
        if ((cpu_single_error || cpu_double_error) && !cpu_rd_window) spurious <= spurious + 1;
    end

    int total = 0, bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cur_val(input int sel);
        case (sel)
            0:       return sr_cnt;
            1:       return int'(corrected_count);
            default: return int'(uncorrectable_count);
        endcase
    endfunction

    task automatic wait_for(input int sel, input int n, input string tag);
        int k;
        k = 0;
        while (cur_val(sel) < n && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_in_time"}, 32'(k < 4000), 32'd1);
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] e);
        @(posedge clk); #1;
        inj_en = 1'b1; inj_addr = a; inj_data = d; inj_err = e;
        @(posedge clk); #1;
        inj_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic s, output logic dd);
        @(posedge clk); #1;
        cpu_rd_window = 1'b1; cpu_read_en = 1'b1; cpu_addr = a;
        @(posedge clk); #1;
        cpu_read_en = 1'b0;
        @(negedge clk);
        d = cpu_data_out; s = cpu_single_error; dd = cpu_double_error;
        @(posedge clk); #1;
        cpu_rd_window = 1'b0;
    endtask

    logic [DW-1:0] rd_d;
    logic          rd_s, rd_dd, prev_busy;
    int            sw_before, sr_before, k;

    initial begin
        rst_n = 1'b0; scrub_en = 1'b0; ram_clr = 1'b1; inj_en = 1'b0;
        inj_addr = '0; inj_data = '0; inj_err = '0;
        cpu_data_in = '0; cpu_addr = '0; cpu_write_en = 1'b0; cpu_read_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(scrub_busy), 0);
        check_val("rst_pass", 32'(pass_done), 0);
        check_val("rst_corr", 32'(corrected_count), 0);
        check_val("rst_unc", 32'(uncorrectable_count), 0);
        check_val("rst_lea", 32'(last_err_addr), 0);
        check_val("rst_we", 32'(ram_write_en), 0);
        check_val("rst_re", 32'(ram_read_en), 0);
        ram_clr = 1'b0; rst_n = 1'b1; scrub_en = 1'b1;

        // Clean full pass: 256 reads then wrap to address 0.
        wait_for(0, 257, "pass1");
        check_val("pass1_seq", 32'(seq_err), 0);
        check_val("pass1_pulses", 32'(pd_cnt), 1);
        check_val("pass1_wrap_addr", 32'(sr_last_addr), 0);
        check_val("pass1_period", 32'(sr_last_t - sr_prev_t), 7);
        check_val("pass1_corr", 32'(corrected_count), 0);
        check_val("pass1_unc", 32'(uncorrectable_count), 0);
        check_val("sat_corr_a", 32'(sat_corr), 32'hF);
        repeat (5) @(posedge clk);
        #1;
        check_val("sat_corr_b", 32'(sat_corr), 32'hF);
        check_val("sat_unc", 32'(sat_unc), 0);

        inject(8'h12, 16'hA5A5, 2'd1);
        inject(8'h33, 16'h5555, 2'd1);
        inject(8'h40, 16'h0F0F, 2'd2);
        inject(8'h50, 16'h7777, 2'd1);

        // Single error at 0x12: writeback visible in the cycle after CHECK.
        wait_for(1, 1, "se12");
        check_val("se12_we", 32'(ram_write_en), 1);
        check_val("se12_addr", 32'(ram_addr), 32'h12);
        check_val("se12_data", 32'(ram_data_in), 32'hA5A5);
        check_val("se12_lea", 32'(last_err_addr), 32'h12);
        cpu_read(8'h12, rd_d, rd_s, rd_dd);
        check_val("se12_rd_data", 32'(rd_d), 32'hA5A5);
        check_val("se12_rd_se", 32'(rd_s), 0);
        check_val("se12_sw_cnt", 32'(sw_cnt), 1);

        // Single error at 0x33 with a CPU write landing during WRITEBACK.
        wait_for(1, 2, "se33");
        sw_before = sw_cnt;
        cpu_write_en = 1'b1; cpu_addr = 8'h33; cpu_data_in = 16'h1234;
        #1;
        check_val("hz_pass_data", 32'(ram_data_in), 32'h1234);
        @(posedge clk); #1;
        cpu_write_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("hz_no_scrub_wr", 32'(sw_cnt), 32'(sw_before));
        check_val("hz_corr", 32'(corrected_count), 2);
        check_val("hz_lea", 32'(last_err_addr), 32'h33);
        cpu_read(8'h33, rd_d, rd_s, rd_dd);
        check_val("hz_rd_data", 32'(rd_d), 32'h1234);
        check_val("hz_rd_se", 32'(rd_s), 0);

        // Double error at 0x40: logged, never written back.
        wait_for(2, 1, "de40");
        check_val("de40_lea", 32'(last_err_addr), 32'h40);
        wait_for(0, sr_cnt + 1, "de40_next");
        check_val("de40_no_write", 32'(wr40), 0);
        check_val("de40_corr", 32'(corrected_count), 2);
        check_val("de40_no_cpu_flag", 32'(spurious), 0);

        // Catch READ entry, then hold the port with CPU reads for 10 cycles.
        prev_busy = scrub_busy;
        k = 0;
        while (!(scrub_busy && !prev_busy) && k < 100) begin
            prev_busy = scrub_busy;
            @(posedge clk); #1;
            k++;
        end
        check_val("stall_sync", 32'(k < 100), 1);
        sr_before = sr_cnt;
        cpu_rd_window = 1'b1; cpu_read_en = 1'b1; cpu_addr = 8'h12;
        repeat (10) @(posedge clk);
        #1;
        check_val("stall_no_issue", 32'(sr_cnt), 32'(sr_before));
        check_val("stall_cpu_data", 32'(cpu_data_out), 32'hA5A5);
        check_val("stall_cpu_se", 32'(cpu_single_error), 0);
        cpu_read_en = 1'b0;
        @(negedge clk);
        check_val("stall_issue_re", 32'(ram_read_en), 1);
        check_val("stall_issue_addr", 32'(ram_addr), 32'h42);
        @(posedge clk); #1;
        cpu_rd_window = 1'b0;

        // Asynchronous reset while a writeback to 0x50 is on the port.
        wait_for(1, 3, "se50");
        check_val("rwb_we_before", 32'(ram_write_en), 1);
        check_val("rwb_addr_before", 32'(ram_addr), 32'h50);
        sw_before = sw_cnt;
        rst_n = 1'b0;
        #1;
        check_val("rwb_we", 32'(ram_write_en), 0);
        check_val("rwb_re", 32'(ram_read_en), 0);
        check_val("rwb_addr", 32'(ram_addr), 0);
        check_val("rwb_din", 32'(ram_data_in), 0);
        check_val("rwb_corr", 32'(corrected_count), 0);
        check_val("rwb_unc", 32'(uncorrectable_count), 0);
        check_val("rwb_lea", 32'(last_err_addr), 0);
        check_val("rwb_busy", 32'(scrub_busy), 0);
        check_val("rwb_pass", 32'(pass_done), 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rwb_no_write", 32'(sw_cnt), 32'(sw_before));
        check_val("no_spurious_flags", 32'(spurious), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
